line_window3x3: RTL and testbench

- Neighbouring stage directly downstream of the raster counter and image ROMs; feeds one colour channel's filter kernel inside the self-made wrapper.
- Consumes one pixel per clock plus the raster h/v counters, including blanking.
- Buffers two display lines and emits a registered 3x3 neighbourhood with aligned output counters.
- Taps outside the display area are zero-padded.
- One instance per colour channel.

---
 rtl/line_window3x3.sv | 130 +++++++++++++
 tb/tb_line_window3x3.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/line_window3x3.sv
// Two-line buffered 3x3 neighbourhood generator with zero padding outside the display area.
// Latency WIDTH+2 clocks from pixel to centre tap; no backpressure, one pixel per clock always.
module line_window3x3 #(
  parameter int P_IMGDEPTH = 8,
  parameter int WIDTH      = 400,
  parameter int HEIGHT     = 300,
  parameter int H_DISP     = 320,
  parameter int V_DISP     = 240
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(WIDTH+1)-1:0]   h_count_in,
  input  logic [$clog2(HEIGHT+1)-1:0]  v_count_in,
  input  logic [P_IMGDEPTH-1:0]        pix_in,
  output logic [9*P_IMGDEPTH-1:0]      w_out,
  output logic [$clog2(WIDTH+1)-1:0]   h_count_out,
  output logic [$clog2(HEIGHT+1)-1:0]  v_count_out,
  output logic                         valid_out
);

  localparam int HW = $clog2(WIDTH+1);
  localparam int VW = $clog2(HEIGHT+1);
  localparam int AW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int P  = P_IMGDEPTH;

  localparam logic [HW-1:0] H_ACT  = HW'(H_DISP);
  localparam logic [HW-1:0] H_LAST = HW'(H_DISP-1);
  localparam logic [HW-1:0] H_WRAP = HW'(WIDTH-1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_DISP);
  localparam logic [VW-1:0] V_LAST = VW'(V_DISP-1);
  localparam logic [VW-1:0] V_WRAP = VW'(HEIGHT-1);

  logic [P-1:0]  lb0 [H_DISP];
  logic [P-1:0]  lb1 [H_DISP];
  logic [P-1:0]  col_new [3];
  logic [P-1:0]  col1 [3];
  logic [P-1:0]  col2 [3];
  logic          in_line;
  logic [AW-1:0] addr;
  logic [HW-1:0] cx;
  logic [VW-1:0] v_prev;
  logic [VW-1:0] cy;
  logic          valid_nxt;
  logic          row_ok [3];
  logic          col_ok [3];
  logic [9*P-1:0] win_nxt;

  assign in_line = (h_count_in < H_ACT);
  assign addr    = h_count_in[AW-1:0];

  // Line buffers are deliberately unreset; masking keeps their stale contents off the output.
  always_ff @(posedge clk) begin
    if (in_line) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= pix_in;
    end
  end

  always_comb begin
    col_new[0] = '0;
    col_new[1] = '0;
    col_new[2] = '0;
    if (in_line) begin
      col_new[0] = lb1[addr];
      col_new[1] = lb0[addr];
      col_new[2] = (v_count_in < V_ACT) ? pix_in : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        col1[r] <= '0;
        col2[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        col1[r] <= col_new[r];
        col2[r] <= col1[r];
      end
    end
  end

  // At h==0 the centre is column WIDTH-1 of the previous raster row.
  always_comb begin
    v_prev = (v_count_in == '0) ? V_WRAP : v_count_in - VW'(1);
    cx     = (h_count_in == '0) ? H_WRAP : h_count_in - HW'(1);
    if (h_count_in != '0)
      cy = v_prev;
    else
      cy = (v_prev == '0) ? V_WRAP : v_prev - VW'(1);
    valid_nxt = (cx < H_ACT) && (cy < V_ACT);
  end

  always_comb begin
    row_ok[0] = (cy != '0);
    row_ok[1] = 1'b1;
    row_ok[2] = (cy != V_LAST);
    col_ok[0] = (cx != '0);
    col_ok[1] = 1'b1;
    col_ok[2] = (cx != H_LAST);
    win_nxt   = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (valid_nxt && row_ok[r] && col_ok[c]) begin
          case (c)
            0:       win_nxt[(3*r+c)*P +: P] = col2[r];
            1:       win_nxt[(3*r+c)*P +: P] = col1[r];
            default: win_nxt[(3*r+c)*P +: P] = col_new[r];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_out       <= '0;
      h_count_out <= '0;
      v_count_out <= '0;
      valid_out   <= 1'b0;
    end else begin
      w_out       <= win_nxt;
      h_count_out <= cx;
      v_count_out <= cy;
      valid_out   <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_line_window3x3.sv
// Bench for line_window3x3: a small raster with fixed pixels and a mid-size raster with random pixels.
module tb_line_window3x3;

  localparam int SW = 8,  SH = 6,  SHD = 5,  SVD = 4;
  localparam int MW = 40, MH = 30, MHD = 32, MVD = 24;

  logic        clk = 1'b0;
  logic        rst_s, rst_m;
  logic [5:0]  h_in;
  logic [4:0]  v_in;
  logic [7:0]  pix;
  logic [71:0] w_s, w_m;
  logic [3:0]  ho_s;
  logic [2:0]  vo_s;
  logic [5:0]  ho_m;
  logic [4:0]  vo_m;
  logic        vld_s, vld_m;

  always #5 clk = ~clk;

  line_window3x3 #(.P_IMGDEPTH(8), .WIDTH(SW), .HEIGHT(SH), .H_DISP(SHD), .V_DISP(SVD)) u_small (
    .clk(clk), .rst(rst_s), .h_count_in(h_in[3:0]), .v_count_in(v_in[2:0]), .pix_in(pix),
    .w_out(w_s), .h_count_out(ho_s), .v_count_out(vo_s), .valid_out(vld_s));

  line_window3x3 #(.P_IMGDEPTH(8), .WIDTH(MW), .HEIGHT(MH), .H_DISP(MHD), .V_DISP(MVD)) u_mid (
    .clk(clk), .rst(rst_m), .h_count_in(h_in), .v_count_in(v_in), .pix_in(pix),
    .w_out(w_m), .h_count_out(ho_m), .v_count_out(vo_m), .valid_out(vld_m));

  typedef struct { int h; int v; } coord_t;
  typedef struct { int cx; int cy; logic [71:0] exp; } vec_t;

  int          passed = 0, total = 0;
  bit          use_mid = 1'b0;
  int          cur_w = SW, cur_h = SH, cur_hd = SHD, cur_vd = SVD;
  logic [7:0]  blank_val = 8'h00;
  int          hc = 0, vc = 0;
  coord_t      hist[$];
  int          img [4096];
  logic [71:0] cap [64];
  int          vcount = 0, edges = 0, first_vld = -1;
  vec_t        tbl [5];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Zero-padded neighbourhood of (cx,cy) taken from the latest pixels seen at each display position.
  function automatic logic [71:0] ref_win(input int cx, input int cy);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int x = cx + c - 1;
        int y = cy + r - 1;
        if (x >= 0 && x < cur_hd && y >= 0 && y < cur_vd)
          w[(3*r+c)*8 +: 8] = 8'(img[y*64+x]);
      end
    return w;
  endfunction

  task automatic drive();
    h_in = 6'(hc);
    v_in = 5'(vc);
    if (hc < cur_hd && vc < cur_vd)
      pix = use_mid ? 8'($urandom) : 8'(16*vc + hc);
    else
      pix = use_mid ? 8'($urandom) : blank_val;
  endtask

  // The centre of the window leaving the block is the coordinate sampled WIDTH+2 clock edges
  // earlier, counting the sampling edge itself.
  task automatic tick();
    logic [71:0] aw;
    int ah, av, cx, cy;
    logic avld, ev;
    @(posedge clk);
    if (use_mid ? rst_m : rst_s) begin
      hist.push_back('{hc, vc});
      if (hist.size() > cur_w + 2) void'(hist.pop_front());
      if (hc < cur_hd && vc < cur_vd) img[vc*64+hc] = int'(pix);
      edges++;
    end
    @(negedge clk);
    aw   = use_mid ? w_m : w_s;
    ah   = use_mid ? int'(ho_m) : int'(ho_s);
    av   = use_mid ? int'(vo_m) : int'(vo_s);
    avld = use_mid ? vld_m : vld_s;
    if (hist.size() < cur_w + 2) begin
      check("warmup_valid", {71'b0, avld}, 72'b0);
      check("warmup_window", aw, 72'b0);
    end else begin
      cx = hist[0].h;
      cy = hist[0].v;
      ev = (cx < cur_hd) && (cy < cur_vd);
      check($sformatf("valid@(%0d,%0d)", cx, cy), {71'b0, avld}, {71'b0, ev});
      check("h_count_out", 72'(ah), 72'(cx));
      check("v_count_out", 72'(av), 72'(cy));
      check($sformatf("window@(%0d,%0d)", cx, cy), aw, ev ? ref_win(cx, cy) : 72'b0);
      if (avld) begin
        vcount++;
        if (first_vld < 0) first_vld = edges;
        if (!use_mid && cx < 8 && cy < 8) cap[cy*8+cx] = aw;
      end
    end
    hc++;
    if (hc == cur_w) begin
      hc = 0;
      vc++;
      if (vc == cur_h) vc = 0;
    end
    drive();
  endtask

  task automatic run_frames(input int n, input int exp_valid);
    for (int f = 0; f < n; f++) begin
      vcount = 0;
      repeat (cur_w * cur_h) tick();
      check($sformatf("valid_per_frame%0d", f), 72'(vcount), 72'(exp_valid));
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_centre(%0d,%0d)", tag, tbl[i].cx, tbl[i].cy),
            cap[tbl[i].cy*8 + tbl[i].cx], tbl[i].exp);
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 64; i++) cap[i] = '1;
  endtask

  initial begin
    tbl[0] = '{2, 1, {8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11, 8'h03, 8'h02, 8'h01}};
    tbl[1] = '{0, 0, {8'h11, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{4, 3, {8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h33, 8'h00, 8'h24, 8'h23}};
    tbl[3] = '{4, 0, {8'h00, 8'h14, 8'h13, 8'h00, 8'h04, 8'h03, 8'h00, 8'h00, 8'h00}};
    tbl[4] = '{0, 3, {8'h00, 8'h00, 8'h00, 8'h31, 8'h30, 8'h00, 8'h21, 8'h20, 8'h00}};
    for (int i = 0; i < 4096; i++) img[i] = 0;
    clear_cap();

    rst_s = 1'b0;
    rst_m = 1'b0;
    drive();
    repeat (3) @(negedge clk);
    check("reset_w_out", w_s, 72'b0);
    check("reset_valid", {71'b0, vld_s}, 72'b0);
    check("reset_h_out", 72'(ho_s), 72'b0);
    check("reset_v_out", 72'(vo_s), 72'b0);

    // Frames with zero blanking pixels, released with counters at (0,0).
    rst_s = 1'b1;
    run_frames(2, SHD * SVD);
    check("first_valid_edge", 72'(first_vld), 72'(SW + 2));
    check_table("zero_blank");

    // Blanking forced to FF must not leak into any window.
    blank_val = 8'hFF;
    clear_cap();
    run_frames(2, SHD * SVD);
    check_table("ff_blank");

    // Reset in the middle of row 2, released when the raster is back at (0,0).
    repeat (2 * SW + 3) tick();
    rst_s = 1'b0;
    #1;
    check("midreset_w_out", w_s, 72'b0);
    check("midreset_valid", {71'b0, vld_s}, 72'b0);
    check("midreset_h_out", 72'(ho_s), 72'b0);
    check("midreset_v_out", 72'(vo_s), 72'b0);
    hist.delete();
    for (int guard = 0; guard < SW * SH && !(hc == 0 && vc == 0); guard++) tick();
    check("midreset_realign", 72'(hc + vc), 72'b0);
    rst_s = 1'b1;
    blank_val = 8'h00;
    clear_cap();
    run_frames(2, SHD * SVD);
    check_table("after_reset");

    // Random pixels on the mid-size raster.
    rst_s = 1'b0;
    use_mid = 1'b1;
    cur_w = MW; cur_h = MH; cur_hd = MHD; cur_vd = MVD;
    hist.delete();
    hc = 0;
    vc = 0;
    drive();
    rst_m = 1'b1;
    run_frames(2, MHD * MVD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
